// File: rtl/rd_sched_pkg.sv
// Shared types for the read descriptor scheduler: FSM states, descriptor layout, error codes.
package rd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] beg_addr;
    logic [31:0] end_addr;
  } desc_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last+1, modulo N.
module rr_arbiter
  import rd_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   last,
  output logic [N-1:0]          grant,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int IW = idx_w(N);

  // Walk the rotation backwards so the nearest candidate is the one left standing.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        grant                          = '0;
        grant[(int'(last) + k) % N]    = 1'b1;
        idx                            = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rd_sched.sv
// Shares one packet read controller between N_REQ requesters: round-robin grant, length check,
// single outstanding read with watchdog, recovery gap, then a one-cycle completion report.
module rd_sched
  import rd_sched_pkg::*;
#(
  parameter int          N_REQ          = 2,
  parameter logic [15:0] MAX_LEN        = 16'd1518,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          GAP_CYCLES     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_control,
  input  logic [N_REQ*32-1:0]  req_begin,
  input  logic [N_REQ*32-1:0]  req_end,
  input  logic                 almost_full,
  output logic                 rd_start,
  output logic [31:0]          control,
  output logic [31:0]          pkt_begin,
  output logic [31:0]          pkt_end,
  input  logic                 rd_done,
  output logic                 done_valid,
  output logic [2:0]           done_id,
  output logic [1:0]           done_err,
  output logic                 busy,
  output logic [31:0]          pkt_count
);

  localparam int IW = idx_w(N_REQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   id_q, id_d;
  desc_t           desc_q, desc_d;
  logic [1:0]      err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;

  logic [N_REQ-1:0] gnt_oh;
  logic [IW-1:0]    gnt_idx;
  logic             grant_en;
  desc_t            desc_sel;
  logic [31:0]      len;
  logic             len_ok;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (gnt_oh),
    .idx   (gnt_idx)
  );

  assign grant_en          = (state_q == ST_IDLE) && enable && !almost_full && (|req_valid);
  assign desc_sel.ctrl     = req_control[32*int'(gnt_idx) +: 32];
  assign desc_sel.beg_addr = req_begin[32*int'(gnt_idx) +: 32];
  assign desc_sel.end_addr = req_end[32*int'(gnt_idx) +: 32];
  assign len               = desc_sel.end_addr - desc_sel.beg_addr;
  assign len_ok            = (desc_sel.end_addr > desc_sel.beg_addr) && (len <= {16'h0, MAX_LEN});

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_q    <= IW'(N_REQ - 1);
      id_q      <= '0;
      desc_q    <= '0;
      err_q     <= ERR_OK;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      desc_q    <= desc_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    desc_d    = desc_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          last_d = gnt_idx;
          id_d   = gnt_idx;
          desc_d = desc_sel;
          if (len_ok) begin
            state_d = ST_LAUNCH;
            err_d   = ERR_OK;
          end else begin
            state_d = ST_REPORT;
            err_d   = ERR_LEN;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the last watchdog cycle still counts as success.
        if (rd_done) begin
          state_d   = ST_GAP;
          err_d     = ERR_OK;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          cnt_d     = '0;
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_GAP;
          err_d   = ERR_TIMEOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 32'(GAP_CYCLES - 1)) begin
          state_d = ST_REPORT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = grant_en ? gnt_oh : '0;
    rd_start   = (state_q == ST_LAUNCH);
    done_valid = (state_q == ST_REPORT);
    done_id    = (state_q == ST_REPORT) ? 3'(id_q) : 3'd0;
    done_err   = (state_q == ST_REPORT) ? err_q : ERR_OK;
    busy       = (state_q != ST_IDLE);
  end

  assign control   = desc_q.ctrl;
  assign pkt_begin = desc_q.beg_addr;
  assign pkt_end   = desc_q.end_addr;
  assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_rd_sched.sv
// Bench for rd_sched: transaction-timing reference model plus directed and random stimulus.
module tb_rd_sched;
  import rd_sched_pkg::*;

  localparam int N   = 2;
  localparam int T   = 4096;
  localparam int GAP = 2;
  localparam longint NONE = 64'sh7FFF_FFFF_FFFF_FFFF;

  logic            clk, reset, enable, almost_full, rd_done;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*32-1:0] req_control, req_begin, req_end;
  logic            rd_start, done_valid, busy;
  logic [31:0]     control, pkt_begin, pkt_end, pkt_count;
  logic [2:0]      done_id;
  logic [1:0]      done_err;

  rd_sched #(.N_REQ(N), .MAX_LEN(16'd1518), .TIMEOUT_CYCLES(T), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
    .req_control(req_control), .req_begin(req_begin), .req_end(req_end),
    .almost_full(almost_full), .rd_start(rd_start), .control(control), .pkt_begin(pkt_begin),
    .pkt_end(pkt_end), .rd_done(rd_done), .done_valid(done_valid), .done_id(done_id),
    .done_err(done_err), .busy(busy), .pkt_count(pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model: when things are due to happen, in absolute cycle numbers.
  desc_t  rq[N][$];
  desc_t  m_desc;
  int     m_last, m_id, m_err;
  longint m_start, m_rep, m_idle_at, m_wlo, m_whi, done_at;
  logic [31:0] m_pkt;
  int     dly;
  bit     spur, rec_en;
  int     obs[$];
  int     ready_seen;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  function automatic void model_reset();
    m_last    = N - 1;
    m_id      = 0;
    m_err     = 0;
    m_desc    = '0;
    m_pkt     = 0;
    m_start   = NONE;
    m_rep     = NONE;
    m_wlo     = NONE;
    m_whi     = NONE;
    done_at   = NONE;
    m_idle_at = cyc + 1;
  endfunction

  function automatic desc_t mk(bit bad);
    desc_t d;
    logic [31:0] len;
    d.ctrl     = $urandom;
    d.beg_addr = $urandom_range(0, 32'h7FFF_0000);
    if (!bad) len = $urandom_range(1, 1518);
    else case ($urandom_range(0, 2))
      0:       len = 0;
      1:       len = 1519 + $urandom_range(0, 500);
      default: len = 32'hFFFF_FF00;
    endcase
    d.end_addr = d.beg_addr + len;
    return d;
  endfunction

  task automatic step();
    logic [N-1:0] er;
    logic [31:0]  len;
    int           w;
    bit           idle, ok;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() != 0);
      if (rq[i].size() != 0) begin
        req_control[32*i +: 32] = rq[i][0].ctrl;
        req_begin[32*i +: 32]   = rq[i][0].beg_addr;
        req_end[32*i +: 32]     = rq[i][0].end_addr;
      end
    end
    rd_done = (cyc == done_at) || (spur && $urandom_range(0, 29) == 0);
    #1;
    idle = (cyc >= m_idle_at);
    er   = '0;
    w    = -1;
    if (idle && enable && !almost_full)
      for (int k = 1; k <= N; k++)
        if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
    if (w >= 0) er[w] = 1'b1;
    if (reset) begin
      chk("req_ready",  32'(req_ready), 32'(er));
      chk("rd_start",   32'(rd_start), 32'(cyc == m_start));
      chk("done_valid", 32'(done_valid), 32'(cyc == m_rep));
      chk("done_id",    32'(done_id), (cyc == m_rep) ? 32'(m_id) : 32'd0);
      chk("done_err",   32'(done_err), (cyc == m_rep) ? 32'(m_err) : 32'd0);
      chk("busy",       32'(busy), 32'(!idle));
      chk("pkt_count",  pkt_count, m_pkt);
      chk("control",    control, m_desc.ctrl);
      chk("pkt_begin",  pkt_begin, m_desc.beg_addr);
      chk("pkt_end",    pkt_end, m_desc.end_addr);
      if (req_ready != 0) begin
        ready_seen++;
        if (rec_en) obs.push_back(req_ready[1] ? 1 : 0);
      end
    end
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (w >= 0) begin
        m_last = w;
        m_id   = w;
        m_desc = rq[w].pop_front();
        len    = m_desc.end_addr - m_desc.beg_addr;
        ok     = (m_desc.end_addr > m_desc.beg_addr) && (len <= 32'd1518);
        if (ok) begin
          m_start   = cyc + 1;
          m_wlo     = cyc + 2;
          m_whi     = cyc + 1 + T;
          m_rep     = NONE;
          m_idle_at = NONE;
          done_at   = (dly > 0) ? m_start + dly : NONE;
        end else begin
          m_err     = 1;
          m_rep     = cyc + 1;
          m_idle_at = cyc + 2;
        end
      end else if (m_wlo != NONE && cyc >= m_wlo && cyc <= m_whi) begin
        if (rd_done) begin
          m_err = 0;
          m_pkt = m_pkt + 1;
          m_rep = cyc + GAP + 1;
        end else if (cyc == m_whi) begin
          m_err = 2;
          m_rep = cyc + GAP + 1;
        end
        if (m_rep != NONE) begin
          m_idle_at = m_rep + 1;
          m_wlo     = NONE;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq[0].size() != 0 || rq[1].size() != 0 || cyc < m_idle_at) && n < 10000) begin
      step();
      n++;
    end
    if (n >= 10000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_bound: scheduler still busy after %0d cycles", n);
    end
  endtask

  initial begin
    logic [31:0] base;
    int n;
    reset = 1'b0; enable = 1'b1; almost_full = 1'b0; rd_done = 1'b0;
    req_valid = '0; req_control = '0; req_begin = '0; req_end = '0;
    spur = 0; rec_en = 0; dly = 5; ready_seen = 0;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    reset = 1'b1;

    // Fairness: both requesters loaded with four descriptors each.
    rec_en = 1;
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back(mk(0));
      rq[1].push_back(mk(0));
    end
    drain();
    rec_en = 0;
    chk("fair_count", obs.size(), 8);
    for (int k = 0; k < obs.size(); k++) chk("fair_order", obs[k], k % 2);

    // Single descriptor with a 20-cycle controller response.
    base = pkt_count;
    dly  = 20;
    rq[0].push_back({32'h0000_00A5, 32'h0000_1000, 32'h0000_1040});
    drain();
    chk("single_cnt", pkt_count, base + 1);

    // Back-pressure holds off requester 1.
    almost_full = 1'b1;
    dly = 4;
    rq[1].push_back(mk(0));
    ready_seen = 0;
    repeat (50) step();
    chk("bp_quiet", ready_seen, 0);
    almost_full = 1'b0;
    drain();

    // Bad lengths: empty packet and one byte over the limit.
    base = pkt_count;
    rq[0].push_back({32'h1, 32'h0000_2000, 32'h0000_2000});
    rq[0].push_back({32'h2, 32'h0000_3000, 32'h0000_35EF});
    drain();
    chk("badlen_cnt", pkt_count, base);

    // Timeout, then a normal transfer must still launch.
    dly = 0;
    rq[1].push_back(mk(0));
    drain();
    dly = 7;
    base = pkt_count;
    rq[0].push_back(mk(0));
    drain();
    chk("post_timeout_cnt", pkt_count, base + 1);

    // Reset while waiting on the controller.
    dly = 30;
    rq[1].push_back(mk(0));
    n = 0;
    while (cyc != m_start + 5 && n < 200) begin
      step();
      n++;
    end
    chk("rst_reached_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_cnt", pkt_count, 32'd0);
    rq[1].push_back(mk(0));
    rq[0].push_back(mk(0));
    obs.delete();
    rec_en = 1;
    drain();
    rec_en = 0;
    chk("rst_first_grant", (obs.size() != 0) ? obs[0] : 32'hFF, 0);

    // Random traffic with stray completion pulses.
    spur = 1;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        if (rq[i].size() < 3 && $urandom_range(0, 9) == 0) rq[i].push_back(mk($urandom_range(0, 4) == 0));
      enable      = ($urandom_range(0, 9) != 0);
      almost_full = ($urandom_range(0, 9) == 0);
      dly         = $urandom_range(1, 25);
      step();
    end
    spur = 0; enable = 1'b1; almost_full = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
